// File: rtl/ub_read_streamer_if.sv
// Unified-buffer read streamer bus: burst command, buffer read port and output stream.
// Signal suffixes are from the streamer's point of view (_i into it, _o out of it).
// master = streamer side, slave = environment (command source, buffer, consumer).
// Optional: UB_RD_STRIDE_EN adds cmd_stride_i to the command group.
interface ub_read_streamer_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 12
);
  // burst command
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [ADDR_W-1:0] cmd_base_i;
  logic [LEN_W-1:0]  cmd_len_i;
`ifdef UB_RD_STRIDE_EN
  logic [ADDR_W-1:0] cmd_stride_i;
`endif
  // unified buffer read port
  logic              ub_read_o;
  logic [ADDR_W-1:0] ub_addr_rd_o;
  logic [DATA_W-1:0] ub_data_i;
  // output stream
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic              out_last_o;
  logic              done_o;

  modport master (
    input  cmd_valid_i, cmd_base_i, cmd_len_i,
`ifdef UB_RD_STRIDE_EN
    input  cmd_stride_i,
`endif
    input  ub_data_i, out_ready_i,
    output cmd_ready_o, ub_read_o, ub_addr_rd_o,
    output out_valid_o, out_data_o, out_last_o, done_o
  );

  modport slave (
    output cmd_valid_i, cmd_base_i, cmd_len_i,
`ifdef UB_RD_STRIDE_EN
    output cmd_stride_i,
`endif
    output ub_data_i, out_ready_i,
    input  cmd_ready_o, ub_read_o, ub_addr_rd_o,
    input  out_valid_o, out_data_o, out_last_o, done_o
  );
endinterface

// File: rtl/ub_read_streamer.sv
// Purpose: turns a (base, len) burst command into back-to-back unified buffer reads and streams the words out.
// Latency: command accept to first out_valid_o = READ_LAT+2 cycles; 1 word/cycle sustained.
// Backpressure: reads are credit-gated on FIFO occupancy + reads in flight, so a stalled consumer never loses data.
//
// Ports: clk_i, rst_i (async, active-high) plus bus (ub_read_streamer_if.master):
//   cmd_valid_i/cmd_ready_o/cmd_base_i/cmd_len_i  burst command, len = words-1
//   ub_read_o/ub_addr_rd_o/ub_data_i              buffer read port, data READ_LAT cycles after read
//   out_valid_o/out_ready_i/out_data_o/out_last_o stream to consumer, last on final word
//   done_o                                        one-cycle pulse after the final word handshake
// Optional: define UB_RD_STRIDE_EN for a per-command address stride (cmd_stride_i); default stride 1.
// Interface parameters must match the module's DATA_W/ADDR_W/LEN_W.
module ub_read_streamer #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 15,
  parameter int LEN_W      = 12,
  parameter int READ_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ub_read_streamer_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [SUM_W-1:0] CREDITS  = SUM_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;         // address of the read currently on the port
  logic [LEN_W-1:0]  rem_q, rem_d;           // reads still to issue after the current one
  logic              rd_q, rd_d;             // registered read strobe
  logic              rd_last_q, rd_last_d;   // current read carries the final address
  logic              cmd_ready;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] stride;

  // issue-time flags delayed to line up with ub_data_i
  logic [READ_LAT-1:0] pipe_vld_q;
  logic [READ_LAT-1:0] pipe_last_q;
  logic                cap_vld;
  logic                cap_last;

  // capture FIFO
  logic [DATA_W-1:0] mem_dat_q  [FIFO_DEPTH];
  logic              mem_last_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  fifo_cnt_q;
  logic [CNT_W-1:0]  infl_q;                 // reads committed but not yet captured
  logic [DATA_W-1:0] hold_dat_q;             // last popped word, shown while the FIFO is empty
  logic              hold_last_q;
  logic              out_vld;
  logic              pop;
  logic [DATA_W-1:0] head_dat;
  logic              head_last;
  logic              credit_ok;

`ifdef UB_RD_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;
  assign stride = stride_q;
`else
  assign stride = ADDR_W'(1);
`endif

  // ---------------------------------------------------------------------------
  // Credit: registered counts only, so a pop this cycle frees credit next cycle.
  // Counting a read as in flight from the cycle it is decided (one cycle before
  // it shows on the port) keeps the FIFO from ever being written while full.
  // ---------------------------------------------------------------------------
  assign credit_ok = ({1'b0, fifo_cnt_q} + {1'b0, infl_q}) < CREDITS;

  assign out_vld   = (fifo_cnt_q != '0);
  assign pop       = out_vld & bus.out_ready_i;
  assign head_dat  = mem_dat_q[rd_ptr_q];
  assign head_last = mem_last_q[rd_ptr_q];
  assign cap_vld   = pipe_vld_q[READ_LAT-1];
  assign cap_last  = pipe_last_q[READ_LAT-1];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and read issue. The read decided here appears on
  // ub_read_o next cycle; the command accept itself issues the base address.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    rd_d      = 1'b0;
    rd_last_d = 1'b0;
    cmd_ready = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid_i) begin
          rd_d      = 1'b1;
          addr_d    = bus.cmd_base_i;
          rem_d     = bus.cmd_len_i;
          rd_last_d = (bus.cmd_len_i == '0);
          state_d   = (bus.cmd_len_i == '0) ? S_DRAIN : S_ISSUE;
        end
      end

      S_ISSUE: begin
        // rem_q is at least 1 here
        if (credit_ok) begin
          rd_d      = 1'b1;
          addr_d    = addr_q + stride;
          rem_d     = rem_q - LEN_ONE;
          rd_last_d = (rem_q == LEN_ONE);
          if (rem_q == LEN_ONE) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (pop && head_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read port registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      rem_q     <= '0;
      rd_q      <= 1'b0;
      rd_last_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      rd_q      <= rd_d;
      rd_last_q <= rd_last_d;
      done_q    <= done_d;
    end
  end

`ifdef UB_RD_STRIDE_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stride_q <= '0;
    end else if (cmd_ready && bus.cmd_valid_i) begin
      stride_q <= bus.cmd_stride_i;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read-latency pipe. Clearing it on reset is what drops data returning for
  // reads issued before the reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      pipe_vld_q[0]  <= rd_q;
      pipe_last_q[0] <= rd_last_q;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FIFO storage (no reset needed; occupancy guards every read)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (cap_vld) begin
      mem_dat_q[wr_ptr_q]  <= bus.ub_data_i;
      mem_last_q[wr_ptr_q] <= cap_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FIFO control, in-flight tracking and output hold registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      infl_q      <= '0;
      hold_dat_q  <= '0;
      hold_last_q <= 1'b0;
    end else begin
      if (cap_vld) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PTR_ONE;
        hold_dat_q  <= head_dat;
        hold_last_q <= head_last;
      end

      case ({cap_vld, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_ONE;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_ONE;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase

      case ({rd_d, cap_vld})
        2'b10:   infl_q <= infl_q + CNT_ONE;
        2'b01:   infl_q <= infl_q - CNT_ONE;
        default: infl_q <= infl_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.cmd_ready_o  = cmd_ready;
  assign bus.ub_read_o    = rd_q;
  assign bus.ub_addr_rd_o = addr_q;
  assign bus.out_valid_o  = out_vld;
  assign bus.out_data_o   = out_vld ? head_dat  : hold_dat_q;
  assign bus.out_last_o   = out_vld ? head_last : hold_last_q;
  assign bus.done_o       = done_q;

endmodule
